div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of clock.
REQ-002 clock  input  1  system clock.
REQ-003 resetn  input  1  synchronous active-low reset, sampled on the clock edge.
REQ-004 ctrl_div  input  1  start request, one-cycle pulse or level; sampled every edge.
REQ-005 data_operandA  input  32  dividend, two's complement; sampled only on an accepted start.
REQ-006 data_operandB  input  32  divisor, two's complement; sampled only on an accepted start.
REQ-007 data_result  output  32  signed quotient, truncated toward zero.
REQ-008 data_remainder  output  32  signed remainder; its sign matches the dividend.
REQ-009 data_exception  output  1  divide-by-zero flag for the last completed operation.
REQ-010 data_resultRDY  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high while an operation is in flight.

Function
REQ-012 The FSM SHALL have four states: IDLE, RUN, FIX, DONE; busy SHALL be 1 in RUN and FIX only.
REQ-013 A start SHALL be accepted when ctrl_div=1 on an edge in IDLE or DONE; ctrl_div in RUN/FIX SHALL be ignored, with no queuing.
REQ-014 On acceptance: latch |A| and |B| as 32-bit unsigned (|0x80000000| = 0x80000000), latch sign bits A[31] and B[31], clear the 32-bit partial remainder, clear the 6-bit iteration counter, go to RUN.
REQ-015 RUN SHALL use restoring division, one quotient bit per cycle, MSB first:
- shift {rem, dividend} left by 1
- trial = rem - |B| (adder with inverted divisor, carry-in 1)
- if no borrow: rem = trial, q bit = 1; else q bit = 0
REQ-016 RUN SHALL last exactly 32 cycles; when counter = 31, the next state is FIX.
REQ-017 FIX (1 cycle) SHALL negate the quotient if A[31]^B[31], negate the remainder if A[31], and load data_result/data_remainder.
REQ-018 FIX SHALL set data_exception=1, data_result=0 and data_remainder=0 when the latched divisor is 0; otherwise data_exception=0.
REQ-019 DONE SHALL assert data_resultRDY=1 for exactly one cycle, then go to IDLE, or to RUN if a new start is accepted on that edge.
REQ-020 Latency: data_resultRDY SHALL be high during the cycle after the 34th rising edge following the accepting edge; latency is fixed, including divide-by-zero.
REQ-021 data_result, data_remainder and data_exception SHALL hold their values until the FIX of the next operation; they SHALL NOT change during RUN.
REQ-022 Overflow case 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap); data_exception SHALL be 0.
REQ-023 Arithmetic SHALL be 32-bit modulo; the trial subtraction SHALL use a 33-bit borrow check so that |B| = 0x80000000 divides correctly.

Reset
REQ-024 resetn=0 on an edge SHALL force state to IDLE, with all outputs and internal registers set to 0 (data_result, data_remainder, data_exception, data_resultRDY, busy).
REQ-025 Reset in the middle of an operation SHALL abort it: no data_resultRDY pulse, and previous results are cleared to 0.
REQ-026 ctrl_div asserted on the same edge as resetn=0 SHALL be ignored.

Verification
REQ-027 A=100, B=7, start pulse -> 34 edges later data_resultRDY=1 for 1 cycle, data_result=14, data_remainder=2, data_exception=0.
REQ-028 A=-100 (0xFFFFFF9C), B=7 -> data_result=0xFFFFFFF2 (-14), data_remainder=0xFFFFFFFE (-2); then A=100, B=-7 -> result -14, remainder 2.
REQ-029 A=5, B=0 -> after the same latency: data_exception=1, data_result=0, data_remainder=0; a following 9/3 -> data_exception=0, data_result=3.
REQ-030 A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_remainder=0, data_exception=0; A=0x80000000, B=0x80000000 -> result 1, remainder 0.
REQ-031 Start 100/7, pulse ctrl_div with 1/1 on RUN cycle 5 -> ignored; results are 14 and 2; a start on the DONE cycle (e.g. 9/2) -> accepted back-to-back, result 4, remainder 1.
REQ-032 Start 100/7, drive resetn=0 on RUN cycle 10 -> next cycle busy=0 and all outputs 0; no data_resultRDY pulse within 40 cycles.

Source files
------------

// File: rtl/div_unit_if.sv
// Handshake and data bundle for the sequential signed divider.
interface div_unit_if;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_div, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_div, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_unit.sv
// 32-bit signed restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up in a final cycle, fixed latency including divide-by-zero.
module div_unit (
  input  logic       clock,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] res_q, res_d;
  logic [31:0] remo_q, remo_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        borrow;

  // Shifted partial remainder is 33 bits wide so |B| = 0x80000000 works.
  always_comb begin
    rem_sh = {rem_q, dvd_q[31]};
    diff   = {1'b0, rem_sh} + {2'b11, ~dvs_q} + 34'd1;
    borrow = diff[33];
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    remo_d  = remo_q;
    exc_d   = exc_q;
    rdy_d   = (state_q == DONE);

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.ctrl_div) begin
          dvd_d   = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
          dvs_d   = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;
          sa_d    = bus.data_operandA[31];
          sb_d    = bus.data_operandB[31];
          rem_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        dvd_d = {dvd_q[30:0], ~borrow};
        rem_d = borrow ? rem_sh[31:0] : diff[31:0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        if (dvs_q == '0) begin
          exc_d  = 1'b1;
          res_d  = '0;
          remo_d = '0;
        end else begin
          exc_d  = 1'b0;
          res_d  = (sa_q ^ sb_q) ? (32'd0 - dvd_q) : dvd_q;
          remo_d = sa_q ? (32'd0 - rem_q) : rem_q;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      res_q   <= '0;
      remo_q  <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      remo_q  <= remo_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_remainder = remo_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = (state_q == RUN) || (state_q == FIX);

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit with hand-computed quotients/remainders.
module tb_div_unit;
  logic clock = 1'b0;
  logic resetn;

  div_unit_if bus ();

  div_unit dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_div      = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_div      = 1'b0;
  endtask

  // Edges counted from the accepting edge until data_resultRDY is seen; 0 if none.
  task automatic wait_rdy(output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    for (int n = 1; n <= 60; n++) begin
      if (!seen) begin
        @(posedge clock);
        #1;
        if (bus.data_resultRDY) begin
          seen = 1;
          lat  = n;
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ee);
    int lat;
    start_op(a, b);
    check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
    wait_rdy(lat);
    check({tag, " latency"}, lat, 32'd34);
    check({tag, " quot"}, bus.data_result, eq);
    check({tag, " rem"}, bus.data_remainder, er);
    check({tag, " exc"}, {31'd0, bus.data_exception}, {31'd0, ee});
    @(posedge clock);
    #1;
    check({tag, " rdy drop"}, {31'd0, bus.data_resultRDY}, 32'd0);
  endtask

  initial begin
    int edges;
    int lat;
    int rdy_seen;

    bus.ctrl_div      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    resetn            = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset quot", bus.data_result, 32'd0);
    check("reset rem", bus.data_remainder, 32'd0);
    check("reset exc", {31'd0, bus.data_exception}, 32'd0);
    check("reset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    run_op("100/7",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    run_op("-100/7",  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0);
    run_op("100/-7",  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0);
    run_op("-7/-2",   32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0);
    run_op("5/0",     32'd5,          32'd0,          32'd0,          32'd0,          1'b1);
    run_op("9/3",     32'd9,          32'd3,          32'd3,          32'd0,          1'b0);
    run_op("min/-1",  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
    run_op("min/min", 32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0);
    run_op("max/min", 32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF,   1'b0);

    // Start ignored mid-RUN, then back-to-back start on the DONE cycle.
    start_op(32'd100, 32'd7);
    edges = 0;
    repeat (5) begin
      @(posedge clock);
      #1;
      edges++;
    end
    check("hold quot in RUN", bus.data_result, 32'd0);
    check("hold rem in RUN", bus.data_remainder, 32'h7FFFFFFF);
    bus.data_operandA = 32'd1;
    bus.data_operandB = 32'd1;
    bus.ctrl_div      = 1'b1;
    @(posedge clock);
    #1;
    edges++;
    bus.ctrl_div = 1'b0;
    while (edges < 33) begin
      @(posedge clock);
      #1;
      edges++;
    end
    check("done busy", {31'd0, bus.busy}, 32'd0);
    check("done rdy early", {31'd0, bus.data_resultRDY}, 32'd0);
    bus.data_operandA = 32'd9;
    bus.data_operandB = 32'd2;
    bus.ctrl_div      = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_div = 1'b0;
    check("ign rdy", {31'd0, bus.data_resultRDY}, 32'd1);
    check("ign quot", bus.data_result, 32'd14);
    check("ign rem", bus.data_remainder, 32'd2);
    check("b2b busy", {31'd0, bus.busy}, 32'd1);
    wait_rdy(lat);
    check("b2b latency", lat, 32'd34);
    check("b2b quot", bus.data_result, 32'd4);
    check("b2b rem", bus.data_remainder, 32'd1);

    // Abort by reset mid-operation; ctrl_div during reset is ignored.
    start_op(32'd100, 32'd7);
    repeat (10) @(posedge clock);
    #1;
    resetn       = 1'b0;
    bus.ctrl_div = 1'b1;
    @(posedge clock);
    #1;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort quot", bus.data_result, 32'd0);
    check("abort rem", bus.data_remainder, 32'd0);
    check("abort exc", {31'd0, bus.data_exception}, 32'd0);
    check("abort rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    bus.ctrl_div = 1'b0;
    resetn       = 1'b1;
    rdy_seen     = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) rdy_seen++;
    end
    check("abort no rdy", rdy_seen, 32'd0);
    check("abort idle busy", {31'd0, bus.busy}, 32'd0);

    run_op("post-reset 100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
